// File: rtl/lab2_proc_multi_drop_unit_pkg.sv
// Shared constants and helpers for the multi-drop unit.
package lab2_proc_multi_drop_unit_pkg;

   // Width of a 4-byte memory response message.
   localparam int unsigned MEM_RESP_4B_NBITS = 47;

   // Bits needed to hold a drop count in the range 0..max_drops.
   function automatic int unsigned drop_cnt_nbits(input int unsigned max_drops);
      return $clog2(max_drops + 1);
   endfunction

endpackage

// File: rtl/lab2_proc_drop_counter.sv
// Saturating up/down counter of outstanding drop requests with sticky overflow.
// eff is the count including this cycle's increment; dec is only asserted
// by the caller when eff is non-zero.
module lab2_proc_drop_counter
   import lab2_proc_multi_drop_unit_pkg::*;
#(
   parameter  int unsigned p_max_drops = 4,
   localparam int unsigned CNT_NBITS   = drop_cnt_nbits(p_max_drops)
)(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 inc,
   input  logic                 dec,
   output logic [CNT_NBITS-1:0] count,
   output logic [CNT_NBITS:0]   eff,
   output logic                 ovf
);

   localparam logic [CNT_NBITS:0]   MAX_E = (CNT_NBITS+1)'(p_max_drops);
   localparam logic [CNT_NBITS-1:0] MAX_C = CNT_NBITS'(p_max_drops);

   logic [CNT_NBITS-1:0] r_count;
   logic                 r_ovf;
   logic [CNT_NBITS:0]   w_eff_dec;
   logic                 w_sat;

   assign eff       = {1'b0, r_count} + {{CNT_NBITS{1'b0}}, inc};
   assign w_eff_dec = eff - {{CNT_NBITS{1'b0}}, dec};
   assign w_sat     = (eff > MAX_E);

   // Count register: holds at the maximum on overflow, otherwise eff minus discard.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_count <= '0;
         r_ovf   <= 1'b0;
      end else begin
         r_count <= w_sat ? MAX_C : w_eff_dec[CNT_NBITS-1:0];
         if (w_sat) r_ovf <= 1'b1;
      end
   end

   assign count = r_count;
   assign ovf   = r_ovf;

endmodule

// File: rtl/lab2_proc_multi_drop_unit.sv
// Drop unit between the memory response stream and fetch: discards one
// response per outstanding squash, oldest first, with an optional output pipe.
module lab2_proc_multi_drop_unit
   import lab2_proc_multi_drop_unit_pkg::*;
#(
   parameter  int unsigned p_msg_nbits  = MEM_RESP_4B_NBITS,
   parameter  int unsigned p_max_drops  = 4,
   parameter  int unsigned p_buffered   = 0,
   parameter  int unsigned p_stat_nbits = 16,
   localparam int unsigned CNT_NBITS    = drop_cnt_nbits(p_max_drops)
)(
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    drop,
   input  logic [p_msg_nbits-1:0]  istream_msg,
   input  logic                    istream_val,
   output logic                    istream_rdy,
   output logic [p_msg_nbits-1:0]  ostream_msg,
   output logic                    ostream_val,
   input  logic                    ostream_rdy,
   output logic [CNT_NBITS-1:0]    pending,
   output logic                    drop_ovf,
   output logic [p_stat_nbits-1:0] num_dropped
);

   logic                    w_drop;
   logic                    w_inc;
   logic                    w_dec;
   logic                    w_discard;
   logic                    w_eff_nz;
   logic [CNT_NBITS:0]      w_eff;
   logic [CNT_NBITS-1:0]    w_count;
   logic                    w_ovf;
   logic [p_stat_nbits-1:0] r_num_dropped;

   // Drop pulses are ignored while reset is held.
   assign w_drop   = drop & reset;
   assign w_eff_nz = (w_eff != '0);

   lab2_proc_drop_counter #(.p_max_drops(p_max_drops)) u_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (w_inc),
      .dec   (w_dec),
      .count (w_count),
      .eff   (w_eff),
      .ovf   (w_ovf)
   );

   generate
      if (p_buffered == 0) begin : g_unbuf
         // Pass-through: while any drop is owed, swallow input and hide output.
         assign w_inc       = w_drop;
         assign w_dec       = reset & istream_val & w_eff_nz;
         assign istream_rdy = reset & (w_eff_nz | ostream_rdy);
         assign ostream_val = reset & istream_val & ~w_eff_nz;
         assign ostream_msg = istream_msg;
         assign w_discard   = w_dec;
      end else begin : g_buf
         logic                   r_buf_v;
         logic [p_msg_nbits-1:0] r_buf_msg;
         logic                   w_deq;
         logic                   w_kill;
         logic                   w_enq;

         // The held entry is the oldest undelivered message, so it absorbs a
         // drop first unless it leaves this cycle.
         assign w_deq       = reset & r_buf_v & ostream_rdy;
         assign w_kill      = w_drop & r_buf_v & ~w_deq;
         assign w_inc       = w_drop & ~w_kill;
         assign w_dec       = reset & istream_val & w_eff_nz;
         assign istream_rdy = reset & (w_eff_nz | ~r_buf_v | w_deq | w_kill);
         assign w_enq       = reset & istream_val & ~w_eff_nz & istream_rdy;
         assign ostream_val = reset & r_buf_v;
         assign ostream_msg = r_buf_msg;
         assign w_discard   = w_dec | w_kill;

         // Output pipe register; a new entry replaces one leaving or killed.
         always_ff @(posedge clk) begin
            if (!reset) begin
               r_buf_v <= 1'b0;
            end else if (w_enq) begin
               r_buf_v   <= 1'b1;
               r_buf_msg <= istream_msg;
            end else if (w_deq | w_kill) begin
               r_buf_v <= 1'b0;
            end
         end
      end
   endgenerate

   // Discard statistics, wrapping naturally at the counter width.
   always_ff @(posedge clk) begin
      if (!reset)         r_num_dropped <= '0;
      else if (w_discard) r_num_dropped <= r_num_dropped + 1'b1;
   end

   assign pending     = w_count;
   assign drop_ovf    = w_ovf;
   assign num_dropped = r_num_dropped;

endmodule

// File: tb/tb_lab2_proc_multi_drop_unit.sv
// Scoreboard bench driving three configurations of the drop unit with shared
// stimulus: unbuffered, buffered, and unbuffered with one drop slot and a
// 3-bit statistics counter.
module tb_lab2_proc_multi_drop_unit;

   localparam int MSGW = 47;

   logic            clk = 1'b0;
   logic            reset = 1'b0;
   logic            drop = 1'b0;
   logic            istream_val = 1'b0;
   logic            ostream_rdy = 1'b0;
   logic [MSGW-1:0] istream_msg = '0;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc(input bit rst_n, input bit d, input bit v,
                      input logic [MSGW-1:0] m, input bit r);
      @(posedge clk);
      #1;
      reset       = rst_n;
      drop        = d;
      istream_val = v;
      istream_msg = m;
      ostream_rdy = r;
   endtask

   for (genvar g = 0; g < 3; g++) begin : g_cfg
      localparam int BUF  = (g == 1) ? 1 : 0;
      localparam int MAXD = (g == 2) ? 1 : 4;
      localparam int SW   = (g == 2) ? 3 : 16;
      localparam int CW   = $clog2(MAXD + 1);

      logic            irdy;
      logic            oval;
      logic [MSGW-1:0] omsg;
      logic [CW-1:0]   pend;
      logic            ovf;
      logic [SW-1:0]   ndrop;

      lab2_proc_multi_drop_unit #(
         .p_msg_nbits (MSGW),
         .p_max_drops (MAXD),
         .p_buffered  (BUF),
         .p_stat_nbits(SW)
      ) u_dut (
         .clk        (clk),
         .reset      (reset),
         .drop       (drop),
         .istream_msg(istream_msg),
         .istream_val(istream_val),
         .istream_rdy(irdy),
         .ostream_msg(omsg),
         .ostream_val(oval),
         .ostream_rdy(ostream_rdy),
         .pending    (pend),
         .drop_ovf   (ovf),
         .num_dropped(ndrop)
      );

      // Messages accepted and not yet delivered or discarded, oldest first.
      logic [MSGW-1:0] exp_q[$];
      int              m_pend  = 0;
      int              m_ndrop = 0;
      bit              m_ovf   = 1'b0;

      // Reference model: owed drops are an integer; each accepted message
      // either pays off one owed drop or joins the delivery queue.
      initial begin
         int d, eff;
         bit have, kill, e_rdy, e_val;
         @(posedge clk);
         forever begin
            @(negedge clk);
            if (!reset) begin
               check($sformatf("cfg%0d rdy_in_reset", g), irdy, 0);
               check($sformatf("cfg%0d val_in_reset", g), oval, 0);
               m_pend  = 0;
               m_ovf   = 1'b0;
               m_ndrop = 0;
               exp_q.delete();
            end else begin
               check($sformatf("cfg%0d pending", g), pend, m_pend);
               check($sformatf("cfg%0d drop_ovf", g), ovf, m_ovf);
               check($sformatf("cfg%0d num_dropped", g), ndrop, m_ndrop % (1 << SW));
               have  = exp_q.size() > 0;
               kill  = (BUF != 0) && drop && have && !ostream_rdy;
               d     = (drop && !kill) ? 1 : 0;
               eff   = m_pend + d;
               if (BUF != 0) begin
                  e_val = have;
                  e_rdy = (eff > 0) || !have || ostream_rdy || kill;
               end else begin
                  e_val = istream_val && (eff == 0);
                  e_rdy = (eff > 0) || ostream_rdy;
               end
               check($sformatf("cfg%0d ostream_val", g), oval, e_val);
               check($sformatf("cfg%0d istream_rdy", g), irdy, e_rdy);
               if (eff > MAXD) m_ovf = 1'b1;
               if (kill) begin
                  void'(exp_q.pop_front());
                  m_ndrop++;
               end
               if (istream_val && e_rdy) begin
                  if (eff > 0) begin
                     eff--;
                     m_ndrop++;
                  end else begin
                     exp_q.push_back(istream_msg);
                  end
               end
               m_pend = (eff > MAXD) ? MAXD : eff;
            end
         end
      end

      // Monitor: every delivered message must be the oldest expected one.
      initial begin
         @(posedge clk);
         forever begin
            @(negedge clk);
            #2;
            if (oval && ostream_rdy) begin
               if (exp_q.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL cfg%0d unexpected_output: got %0h expected nothing at %0t",
                           g, omsg, $time);
               end else begin
                  check($sformatf("cfg%0d out_msg", g), omsg, exp_q.pop_front());
               end
            end
         end
      end
   end

   initial begin
      logic [63:0] rnd;
      repeat (3) cyc(0, 1, 1, 47'h7, 1);
      cyc(1, 0, 0, '0, 1);

      // Plain traffic, random downstream ready.
      cyc(1, 0, 1, 47'hA, 1'($urandom));
      cyc(1, 0, 1, 47'hB, 1'($urandom));
      cyc(1, 0, 1, 47'hC, 1'($urandom));
      repeat (3) cyc(1, 0, 0, '0, 1);

      // Drop coinciding with a message.
      cyc(1, 1, 1, 47'h11, 1);
      repeat (2) cyc(1, 0, 0, '0, 1);

      // Three drops ahead of five messages.
      repeat (3) cyc(1, 1, 0, '0, 1);
      for (int i = 1; i <= 5; i++) cyc(1, 0, 1, 47'(i), 1);
      repeat (2) cyc(1, 0, 0, '0, 1);

      // Overflow: five drops into four slots, then four messages.
      repeat (5) cyc(1, 1, 0, '0, 1);
      for (int i = 0; i < 4; i++) cyc(1, 0, 1, 47'(8'h60 + i), 1);
      repeat (2) cyc(1, 0, 0, '0, 1);

      // Held entry killed by a drop while downstream stalls.
      cyc(1, 0, 0, '0, 1);
      cyc(1, 0, 1, 47'h22, 0);
      cyc(1, 0, 0, '0, 0);
      cyc(1, 1, 0, '0, 0);
      cyc(1, 0, 1, 47'h33, 1);
      repeat (3) cyc(1, 0, 0, '0, 1);

      // Reset clears owed drops.
      repeat (2) cyc(1, 1, 0, '0, 1);
      cyc(0, 0, 0, '0, 1);
      cyc(1, 0, 0, '0, 1);
      cyc(1, 0, 1, 47'h44, 1);
      repeat (3) cyc(1, 0, 0, '0, 1);

      // Randomized traffic with occasional reset.
      for (int i = 0; i < 2000; i++) begin
         rnd = {$urandom, $urandom};
         cyc(($urandom_range(0, 199) != 0), ($urandom_range(0, 4) == 0),
             1'($urandom_range(0, 1)), rnd[MSGW-1:0], ($urandom_range(0, 3) != 0));
      end

      repeat (6) cyc(1, 0, 0, '0, 1);
      @(negedge clk);
      #4;
      check("cfg0 drained", g_cfg[0].exp_q.size(), 0);
      check("cfg1 drained", g_cfg[1].exp_q.size(), 0);
      check("cfg2 drained", g_cfg[2].exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
